vga_pixel_pipe: RTL and testbench

VGA_PIXEL_PIPE -- requirements
Module: vga_pixel_pipe

---
 rtl/vga_pixel_pipe_if.sv | 49 ++++
 rtl/vga_pixel_pipe.sv | 91 +++++++++
 tb/tb_vga_pixel_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_pipe_if.sv
// Bus bundle for vga_pixel_pipe: raster in, framebuffer read port, palette write port, video out.
// Cursor signals exist only when VGA_CURSOR_EN is defined.
interface vga_pixel_pipe_if;
  // No valid/ready on any signal: the pipe is free-running and every stage advances every clock.
  logic        hsync_in;
  logic        vsync_in;
  logic        blank_b_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [14:0] fb_addr;
  logic [3:0]  fb_rdata;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic        hsync;
  logic        vsync;
  logic        blank_b;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        frame_start;
`ifdef VGA_CURSOR_EN
  logic [9:0]  cursor_x;
  logic [9:0]  cursor_y;
  logic [11:0] cursor_rgb;

  modport master (
    output hsync_in, vsync_in, blank_b_in, x, y, fb_rdata,
    output pal_we, pal_waddr, pal_wdata, cursor_x, cursor_y, cursor_rgb,
    input  fb_addr, hsync, vsync, blank_b, r, g, b, frame_start
  );
  modport slave (
    input  hsync_in, vsync_in, blank_b_in, x, y, fb_rdata,
    input  pal_we, pal_waddr, pal_wdata, cursor_x, cursor_y, cursor_rgb,
    output fb_addr, hsync, vsync, blank_b, r, g, b, frame_start
  );
`else
  modport master (
    output hsync_in, vsync_in, blank_b_in, x, y, fb_rdata,
    output pal_we, pal_waddr, pal_wdata,
    input  fb_addr, hsync, vsync, blank_b, r, g, b, frame_start
  );
  modport slave (
    input  hsync_in, vsync_in, blank_b_in, x, y, fb_rdata,
    input  pal_we, pal_waddr, pal_wdata,
    output fb_addr, hsync, vsync, blank_b, r, g, b, frame_start
  );
`endif
endinterface

// File: rtl/vga_pixel_pipe.sv
// 3-cycle VGA pixel pipe: framebuffer address, external synchronous read, palette lookup.
// Optional 8x8 hardware cursor overlay when VGA_CURSOR_EN is defined.
module vga_pixel_pipe #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2
) (
  input logic             clk,
  input logic             reset,
  vga_pixel_pipe_if.slave bus
);

  logic [14:0] row, row_c, col, addr_next;
  logic [14:0] fb_addr_q;
  logic [2:0]  hs_d, vs_d, bl_d;
  logic [11:0] rgb_q;
  logic        frame_start_q;
  logic [11:0] pal [16];

  // Rows past the framebuffer clamp to the last row so the product never wraps.
  always_comb begin
    row       = 15'(bus.y >> SCALE_SHIFT);
    row_c     = (row < 15'(FB_H)) ? row : 15'(FB_H - 1);
    col       = 15'(bus.x >> SCALE_SHIFT);
    addr_next = row_c * 15'(FB_W) + col;
  end

`ifdef VGA_CURSOR_EN
  logic        cur_hit;
  logic [1:0]  hit_d;
  logic [11:0] crgb_d1, crgb_d2;

  // 11-bit bounds so a cursor at the right/bottom edge does not wrap to column/line 0.
  always_comb begin
    cur_hit = ({1'b0, bus.x} >= {1'b0, bus.cursor_x}) &&
              ({1'b0, bus.x} <  ({1'b0, bus.cursor_x} + 11'd8)) &&
              ({1'b0, bus.y} >= {1'b0, bus.cursor_y}) &&
              ({1'b0, bus.y} <  ({1'b0, bus.cursor_y} + 11'd8));
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_addr_q     <= '0;
      hs_d          <= 3'b111;
      vs_d          <= 3'b111;
      bl_d          <= 3'b000;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < 16; i++) pal[i] <= {3{4'(i)}};
`ifdef VGA_CURSOR_EN
      hit_d         <= '0;
      crgb_d1       <= '0;
      crgb_d2       <= '0;
`endif
    end else begin
      // Stage 1: address; the memory read register acts as stage 2.
      fb_addr_q <= bus.blank_b_in ? addr_next : 15'd0;
      hs_d      <= {hs_d[1:0], bus.hsync_in};
      vs_d      <= {vs_d[1:0], bus.vsync_in};
      bl_d      <= {bl_d[1:0], bus.blank_b_in};
`ifdef VGA_CURSOR_EN
      hit_d     <= {hit_d[0], cur_hit};
      crgb_d1   <= bus.cursor_rgb;
      crgb_d2   <= crgb_d1;
`endif
      // Stage 3: bl_d[1] is the blank that lands on the output with this colour.
      if (!bl_d[1])
        rgb_q <= '0;
`ifdef VGA_CURSOR_EN
      else if (hit_d[1])
        rgb_q <= crgb_d2;
`endif
      else
        rgb_q <= pal[bus.fb_rdata];
      frame_start_q <= vs_d[2] & ~vs_d[1];
      // Written after the lookup above reads the old entry, so a same-cycle write shows next cycle.
      if (bus.pal_we) pal[bus.pal_waddr] <= bus.pal_wdata;
    end
  end

  assign bus.fb_addr     = fb_addr_q;
  assign bus.hsync       = hs_d[2];
  assign bus.vsync       = vs_d[2];
  assign bus.blank_b     = bl_d[2];
  assign bus.r           = rgb_q[11:8];
  assign bus.g           = rgb_q[7:4];
  assign bus.b           = rgb_q[3:0];
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe with a synchronous framebuffer model (data = addr[3:0] or an override).
// Define VGA_CURSOR_EN for both files to exercise the cursor overlay.
module tb_vga_pixel_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_pixel_pipe_if bus ();

  vga_pixel_pipe #(.FB_W(160), .FB_H(120), .SCALE_SHIFT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic       ovr_en  = 1'b1;
  logic [3:0] ovr_val = 4'd0;

  // Framebuffer returns data one cycle after sampling fb_addr.
  always @(posedge clk) bus.fb_rdata <= ovr_en ? ovr_val : bus.fb_addr[3:0];

  function automatic logic [3:0] exp_idx(input logic [9:0] px, input logic [9:0] py);
    int a;
    a = (int'(py) >> 2) * 160 + (int'(px) >> 2);
    return a[3:0];
  endfunction

  task automatic drive(input logic [9:0] px, input logic [9:0] py, input logic bl,
                       input logic hs, input logic vs);
    bus.x = px; bus.y = py; bus.blank_b_in = bl; bus.hsync_in = hs; bus.vsync_in = vs;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    tests_run++; if (bus.hsync !== 1'b1) begin tests_failed++; $display("FAIL reset_hsync: got %b want 1", bus.hsync); end
    tests_run++; if (bus.vsync !== 1'b1) begin tests_failed++; $display("FAIL reset_vsync: got %b want 1", bus.vsync); end
    tests_run++; if (bus.blank_b !== 1'b0) begin tests_failed++; $display("FAIL reset_blank: got %b want 0", bus.blank_b); end
    tests_run++; if ({bus.r, bus.g, bus.b} !== 12'h000) begin tests_failed++; $display("FAIL reset_rgb: got %h want 000", {bus.r, bus.g, bus.b}); end
    tests_run++; if (bus.frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_fs: got %b want 0", bus.frame_start); end
    tests_run++; if (bus.fb_addr !== 15'd0) begin tests_failed++; $display("FAIL reset_addr: got %0d want 0", bus.fb_addr); end
  endtask

  task automatic test_basic;
    @(negedge clk);
    ovr_en = 1'b1; ovr_val = 4'd5;
    drive(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.fb_addr !== 15'd0) begin tests_failed++; $display("FAIL basic_addr: got %0d want 0", bus.fb_addr); end
    @(negedge clk);
    tests_run++; if (bus.blank_b !== 1'b0) begin tests_failed++; $display("FAIL basic_blank_c2: got %b want 0", bus.blank_b); end
    @(negedge clk);
    tests_run++; if ({bus.r, bus.g, bus.b} !== 12'h555) begin tests_failed++; $display("FAIL basic_rgb_c3: got %h want 555", {bus.r, bus.g, bus.b}); end
    tests_run++; if (bus.blank_b !== 1'b1) begin tests_failed++; $display("FAIL basic_blank_c3: got %b want 1", bus.blank_b); end
  endtask

  task automatic test_addr;
    logic [9:0]  xs [4] = '{10'd639, 10'd4, 10'd100, 10'd300};
    logic [9:0]  ys [4] = '{10'd479, 10'd4, 10'd200, 10'd300};
    logic        bs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [14:0] es [4] = '{15'd19199, 15'd161, 15'd8025, 15'd0};
    for (int i = 0; i < 4; i++) begin
      drive(xs[i], ys[i], bs[i], 1'b1, 1'b1);
      @(negedge clk);
      tests_run++;
      if (bus.fb_addr !== es[i]) begin
        tests_failed++; $display("FAIL addr_%0d: got %0d want %0d", i, bus.fb_addr, es[i]);
      end
    end
  endtask

  task automatic test_palette_stream;
    logic [11:0] exp_q [$];
    logic [11:0] e;
    logic [3:0]  k;
    ovr_en = 1'b0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        e = exp_q.pop_front();
        tests_run++;
        if ({bus.r, bus.g, bus.b} !== e) begin
          tests_failed++; $display("FAIL stream_%0d: got %h want %h", c - 3, {bus.r, bus.g, bus.b}, e);
        end
      end
      if (c < 16) begin
        drive(10'(4 * c), 10'(8 * c), 1'b1, 1'b1, 1'b1);
        k = exp_idx(10'(4 * c), 10'(8 * c));
        exp_q.push_back({k, k, k});
      end
    end
  endtask

  task automatic test_palette_write;
    @(negedge clk);
    ovr_en = 1'b0;
    drive(10'd12, 10'd0, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    bus.pal_we = 1'b1; bus.pal_waddr = 4'd3; bus.pal_wdata = 12'hF00;
    @(negedge clk);
    bus.pal_we = 1'b0;
    tests_run++; if ({bus.r, bus.g, bus.b} !== 12'h333) begin tests_failed++; $display("FAIL palwr_old: got %h want 333", {bus.r, bus.g, bus.b}); end
    @(negedge clk);
    tests_run++; if ({bus.r, bus.g, bus.b} !== 12'hF00) begin tests_failed++; $display("FAIL palwr_new: got %h want f00", {bus.r, bus.g, bus.b}); end
  endtask

  task automatic test_blank;
    ovr_en = 1'b1; ovr_val = 4'd15;
    drive(10'd40, 10'd40, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    tests_run++; if ({bus.r, bus.g, bus.b} !== 12'h000) begin tests_failed++; $display("FAIL blank_rgb: got %h want 000", {bus.r, bus.g, bus.b}); end
    tests_run++; if (bus.hsync !== 1'b0) begin tests_failed++; $display("FAIL blank_hsync: got %b want 0", bus.hsync); end
    drive(10'd40, 10'd40, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    tests_run++; if ({bus.r, bus.g, bus.b} !== 12'hFFF) begin tests_failed++; $display("FAIL active_rgb: got %h want fff", {bus.r, bus.g, bus.b}); end
  endtask

  // Shortened raster (80 x 60) keeps two full frames inside the cycle budget.
  task automatic test_raster;
    localparam int HT = 80, VT = 60;
    logic [2:0] hist [$];
    logic [2:0] e;
    logic       prev_v, exp_fs, hs, vs, bl;
    int         bad, fs_cnt, hc, vc;
    bad = 0; fs_cnt = 0; hc = 0; vc = 0;
    ovr_en = 1'b0;
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    repeat (3) hist.push_back(3'b110);
    prev_v = 1'b1;
    for (int n = 0; n < 2 * HT * VT + 20; n++) begin
      e = hist.pop_front();
      exp_fs = prev_v & ~e[1];
      prev_v = e[1];
      if ({bus.hsync, bus.vsync, bus.blank_b, bus.frame_start} !== {e, exp_fs}) begin
        bad++;
        if (bad <= 4) $display("FAIL raster_cycle_%0d: got %b want %b", n, {bus.hsync, bus.vsync, bus.blank_b, bus.frame_start}, {e, exp_fs});
      end
      if (bus.frame_start === 1'b1) fs_cnt++;
      hs = !(hc >= 66 && hc < 74);
      vs = !(vc >= 50 && vc < 52);
      bl = (hc < 64) && (vc < 48);
      drive(10'(hc), 10'(vc), bl, hs, vs);
      hist.push_back({hs, vs, bl});
      hc = (hc == HT - 1) ? 0 : hc + 1;
      if (hc == 0) vc = (vc == VT - 1) ? 0 : vc + 1;
      @(negedge clk);
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL raster_align: got %0d bad cycles want 0", bad); end
    tests_run++; if (fs_cnt !== 2) begin tests_failed++; $display("FAIL raster_frame_start: got %0d pulses want 2", fs_cnt); end
  endtask

  task automatic test_reset_midline;
    int fs_seen;
    fs_seen = 0;
    ovr_en = 1'b1; ovr_val = 4'd9;
    drive(10'd8, 10'd8, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++; if ({bus.r, bus.g, bus.b} !== 12'h999) begin tests_failed++; $display("FAIL midrst_pre: got %h want 999", {bus.r, bus.g, bus.b}); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if ({bus.hsync, bus.vsync, bus.blank_b, bus.frame_start} !== 4'b1100) begin tests_failed++; $display("FAIL midrst_sync: got %b want 1100", {bus.hsync, bus.vsync, bus.blank_b, bus.frame_start}); end
    tests_run++; if ({bus.r, bus.g, bus.b} !== 12'h000) begin tests_failed++; $display("FAIL midrst_rgb: got %h want 000", {bus.r, bus.g, bus.b}); end
    tests_run++; if (bus.fb_addr !== 15'd0) begin tests_failed++; $display("FAIL midrst_addr: got %0d want 0", bus.fb_addr); end
    @(negedge clk);
    ovr_en = 1'b0;
    drive(10'd12, 10'd0, 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) fs_seen++;
    end
    tests_run++; if (bus.blank_b !== 1'b0) begin tests_failed++; $display("FAIL midrst_blank_c2: got %b want 0", bus.blank_b); end
    @(negedge clk);
    if (bus.frame_start === 1'b1) fs_seen++;
    tests_run++; if ({bus.hsync, bus.blank_b} !== 2'b01) begin tests_failed++; $display("FAIL midrst_c3: got %b want 01", {bus.hsync, bus.blank_b}); end
    tests_run++; if ({bus.r, bus.g, bus.b} !== 12'h333) begin tests_failed++; $display("FAIL midrst_palette: got %h want 333", {bus.r, bus.g, bus.b}); end
    tests_run++; if (fs_seen !== 0) begin tests_failed++; $display("FAIL midrst_fs: got %0d pulses want 0", fs_seen); end
  endtask

`ifdef VGA_CURSOR_EN
  task automatic test_cursor;
    logic [9:0]  cx [6] = '{10'd631, 10'd632, 10'd635, 10'd639, 10'd0, 10'd1};
    logic [9:0]  cy [3] = '{10'd0, 10'd7, 10'd8};
    logic [11:0] exp_q [$];
    logic [11:0] e;
    logic [3:0]  k;
    int          c;
    bus.cursor_x = 10'd632; bus.cursor_y = 10'd0; bus.cursor_rgb = 12'h0F0;
    ovr_en = 1'b0;
    c = 0;
    for (int n = 0; n < 21; n++) begin
      @(negedge clk);
      if (n >= 3) begin
        e = exp_q.pop_front();
        tests_run++;
        if ({bus.r, bus.g, bus.b} !== e) begin
          tests_failed++; $display("FAIL cursor_%0d: got %h want %h", n - 3, {bus.r, bus.g, bus.b}, e);
        end
      end
      if (n < 18) begin
        drive(cx[n % 6], cy[n / 6], 1'b1, 1'b1, 1'b1);
        k = exp_idx(cx[n % 6], cy[n / 6]);
        if (cx[n % 6] >= 10'd632 && cy[n / 6] < 10'd8) exp_q.push_back(12'h0F0);
        else exp_q.push_back({k, k, k});
        c++;
      end
    end
    bus.cursor_x = 10'd1000;
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.pal_we = 1'b0; bus.pal_waddr = 4'd0; bus.pal_wdata = 12'h000;
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
`ifdef VGA_CURSOR_EN
    bus.cursor_x = 10'd1000; bus.cursor_y = 10'd1000; bus.cursor_rgb = 12'h000;
`endif
    test_reset();
    test_basic();
    test_addr();
    test_palette_stream();
    test_palette_write();
    test_blank();
    test_raster();
    test_reset_midline();
`ifdef VGA_CURSOR_EN
    test_cursor();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
